uart_word_io: RTL and testbench
===============================

Name: uart_word_io

Overview:
Word-level bridge between the byte UART receiver/sender and the core. It has two jobs:
- Loader mode: receives a length-prefixed program image, assembles bytes into words and drives instruction-memory writes.
- Run mode: assembles received bytes into words in an RX word FIFO for IN, and serialises words for OUT.
It replaces the ad-hoc per-byte state sequencing in the core's top level with WORD_BYTES-wide, FIFO-buffered I/O.

Parameters:
WORD_BYTES, 4, bytes per word; word width W = 8*WORD_BYTES.
ADDR_WIDTH, 8, instruction-memory address width; max image 2**ADDR_WIDTH words.
FIFO_LOG2, 2, RX word FIFO depth = 2**FIFO_LOG2.
LOAD_MSB_FIRST, 0, loader byte order: 0 = first byte is bits [7:0].
IO_MSB_FIRST, 1, run-mode RX/TX byte order: 1 = first byte is bits [W-1:W-8].

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
rx_data  in  8  byte from receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to sender
tx_enable  out  1  send request to sender
tx_ready  in  1  sender idle; drops while a byte is in flight
load_start  in  1  pulse: enter loader mode
load_busy  out  1  loader active
load_done  out  1  one-cycle pulse at end of image
load_err  out  1  sticky image error
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_WIDTH  write address
imem_wdata  out  W  write data
in_valid  out  1  RX FIFO not empty
in_ready  in  1  core pops head word
in_data  out  W  RX FIFO head word
out_valid  in  1  core offers word to send
out_ready  out  1  serialiser idle, word accepted this cycle if out_valid
out_data  in  W  word to send
rx_overflow  out  1  sticky: a run-mode word was dropped

Behaviour:
- Reset:
  - All outputs are 0, except out_ready, which is 1 one cycle after RST_N deasserts.
  - FIFO is empty, byte counters are 0, and all FSMs are in IDLE/RUN.
  - Reset mid-operation discards the partial word, the FIFO contents and the loader progress.
- Byte assembler:
  - Counter 0..WORD_BYTES-1 advances on each rx_valid.
  - The byte is placed according to LOAD_MSB_FIRST or IO_MSB_FIRST, depending on the current mode.
  - The word completes on the strobe with counter = WORD_BYTES-1.
- Loader FSM, states RUN -> HDR -> DATA -> (CHK) -> RUN:
  - RUN: load_start=1 -> HDR, load_busy=1, load_err cleared, byte counter cleared. load_start while busy is ignored.
  - HDR: the first completed word is the length N.
    - N > 2**ADDR_WIDTH: load_err=1, return to RUN with no writes.
    - N = 0: load_done pulse, return to RUN.
    - Otherwise go to DATA with address 0.
  - DATA: each completed word gives imem_we=1 for exactly one cycle, in the cycle after the final byte strobe, with imem_addr = index and imem_wdata = word. After word N-1: load_done pulse, load_busy=0, RUN.
  - While load_busy, received bytes never enter the RX FIFO.
- RX FIFO (run mode):
  - A completed word is pushed in the cycle after the final strobe.
  - Pop occurs when in_valid && in_ready; in_data is registered from the head, first-word fall-through.
  - Push and pop in the same cycle when full: both succeed and the count is unchanged.
  - Push when full without a pop: the word is dropped and rx_overflow is set (sticky until reset).
  - Pointers wrap modulo depth.
- TX serialiser, states IDLE -> WAIT_RDY -> STROBE -> WAIT_BUSY -> WAIT_DONE:
  - IDLE: out_ready=1. out_valid latches out_data, out_ready=0 -> WAIT_RDY.
  - WAIT_RDY: tx_ready=1 -> STROBE.
  - STROBE: tx_data = current byte (per IO_MSB_FIRST), tx_enable=1 for exactly one cycle -> WAIT_BUSY.
  - WAIT_BUSY: tx_ready=0 -> WAIT_DONE.
  - WAIT_DONE: tx_ready=1 -> next byte to STROBE, or after byte WORD_BYTES-1 -> IDLE.
  - tx_data holds its value from STROBE until the next STROBE.
  - The serialiser runs independently of the loader; out_valid during loading is serviced normally.
- Widths:
  - Length header compared as unsigned W bits.
  - imem_addr counter is ADDR_WIDTH+1 bits internally and truncates on output.

Optional Feature:
Macro UART_WORD_IO_CHECKSUM_EN.
- Defined:
  - After word N-1 the loader enters state CHK and receives one more word.
  - If that word equals the mod-2**W sum of the N data words: load_done pulse.
  - Otherwise: load_err=1 with no load_done. Writes already made are not undone.
  - For N = 0 the checksum word (expected 0) is still required.
- Undefined: no CHK state; load_done follows word N-1 directly.

Test Plan:
- Load, defaults: load_start, bytes 02 00 00 00, 78 56 34 12, EF BE AD DE -> imem writes (0, 0x12345678), (1, 0xDEADBEEF); load_done pulse; no FIFO push.
- Run-mode RX, defaults: bytes 12 34 56 78 -> in_valid=1, in_data=0x12345678. Five words with in_ready=0 and depth 4 -> first four retained in order, rx_overflow=1.
- Full FIFO: in_ready=1 held in the same cycle as a fifth word completes -> no overflow, count stays 4.
- TX with a sender model (ready low 10 cycles per byte): out_data=0xA1B2C3D4 -> tx_data sequence A1, B2, C3, D4, each with one-cycle tx_enable; out_ready returns to 1 after the fourth byte's ready rises.
- Length header 0x00000101 (ADDR_WIDTH=8) -> load_err=1, no imem_we, back to run mode. Header 0 -> immediate load_done, or with the macro, after checksum word 0.
- Reset asserted after 2 data bytes of a load -> load_busy=0; the next bytes 01 02 03 04 land in the FIFO as 0x01020304. With the macro: bad checksum -> load_err=1, no load_done.

Source files
------------

// File: rtl/uart_word_io.sv
// Word-level UART bridge: length-prefixed instruction-memory loader, RX word FIFO and TX word serialiser.
// Optional image checksum word enabled by defining UART_WORD_IO_CHECKSUM_EN.
module uart_word_io #(
    parameter int unsigned WORD_BYTES     = 4,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned FIFO_LOG2      = 2,
    parameter int unsigned LOAD_MSB_FIRST = 0,
    parameter int unsigned IO_MSB_FIRST   = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_enable,
    input  logic                    tx_ready,
    input  logic                    load_start,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    load_err,
    output logic                    imem_we,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    output logic [8*WORD_BYTES-1:0] imem_wdata,
    output logic                    in_valid,
    input  logic                    in_ready,
    output logic [8*WORD_BYTES-1:0] in_data,
    input  logic                    out_valid,
    output logic                    out_ready,
    input  logic [8*WORD_BYTES-1:0] out_data,
    output logic                    rx_overflow
);

    localparam int unsigned W     = 8 * WORD_BYTES;
    localparam int unsigned CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned IDX_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned FC_W  = FIFO_LOG2 + 1;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);
    localparam logic [W-1:0]     MAX_LEN   = W'(64'd1 << ADDR_WIDTH);
    localparam logic [FC_W-1:0]  FIFO_FULL = FC_W'(DEPTH);
    localparam bit               LOAD_MSB  = (LOAD_MSB_FIRST != 0);
    localparam bit               IO_MSB    = (IO_MSB_FIRST != 0);

    // Byte lane of the byte at position cnt within a word
    function automatic int unsigned byte_pos(input logic [CNT_W-1:0] cnt, input bit msb_first);
        return msb_first ? (WORD_BYTES - 1 - 32'(cnt)) : 32'(cnt);
    endfunction

    function automatic logic [W-1:0] put_byte(input logic [W-1:0] w, input logic [7:0] b,
                                               input int unsigned lane);
        logic [W-1:0] r;
        r = w;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (i == lane) r[8*i +: 8] = b;
        end
        return r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [W-1:0] w, input int unsigned lane);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (i == lane) r = w[8*i +: 8];
        end
        return r;
    endfunction

    typedef enum logic [1:0] {L_RUN, L_HDR, L_DATA, L_CHK} ld_state_t;
    typedef enum logic [2:0] {T_IDLE, T_WAIT_RDY, T_STROBE, T_WAIT_BUSY, T_WAIT_DONE} tx_state_t;

    ld_state_t ld_state, ld_state_d;

    // ---------------- byte assembler ----------------
    logic [CNT_W-1:0] rx_cnt;
    logic [W-1:0]     rx_acc;
    logic [W-1:0]     rx_word_c;
    logic             start_c;
    logic             word_c;

    // A load_start accepted in RUN restarts the word and drops any byte of that cycle
    assign start_c   = (ld_state == L_RUN) && load_start;
    assign rx_word_c = put_byte(rx_acc, rx_data,
                                byte_pos(rx_cnt, (ld_state != L_RUN) ? LOAD_MSB : IO_MSB));
    assign word_c    = rx_valid && !start_c && (rx_cnt == LAST_BYTE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_cnt <= '0;
            rx_acc <= '0;
        end else if (start_c) begin
            rx_cnt <= '0;
        end else if (rx_valid) begin
            rx_acc <= rx_word_c;
            rx_cnt <= (rx_cnt == LAST_BYTE) ? '0 : rx_cnt + CNT_W'(1);
        end
    end

    // ---------------- loader FSM ----------------
    logic [IDX_W-1:0]      ld_len, ld_len_d;
    logic [IDX_W-1:0]      ld_idx, ld_idx_d;
    logic [IDX_W-1:0]      idx_inc_c;
    logic                  load_busy_d, load_done_d, load_err_d, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_d;
    logic [W-1:0]          imem_wdata_d;
`ifdef UART_WORD_IO_CHECKSUM_EN
    logic [W-1:0]          ld_sum, ld_sum_d;
`endif

    assign idx_inc_c = ld_idx + IDX_W'(1);

    always_comb begin
        ld_state_d   = ld_state;
        ld_len_d     = ld_len;
        ld_idx_d     = ld_idx;
        load_done_d  = 1'b0;
        load_err_d   = load_err;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr;
        imem_wdata_d = imem_wdata;
`ifdef UART_WORD_IO_CHECKSUM_EN
        ld_sum_d     = ld_sum;
`endif
        case (ld_state)
            L_RUN: begin
                if (load_start) begin
                    ld_state_d = L_HDR;
                    load_err_d = 1'b0;
                    ld_idx_d   = '0;
`ifdef UART_WORD_IO_CHECKSUM_EN
                    ld_sum_d   = '0;
`endif
                end
            end
            L_HDR: begin
                if (word_c) begin
                    if (rx_word_c > MAX_LEN) begin
                        load_err_d = 1'b1;
                        ld_state_d = L_RUN;
                    end else if (rx_word_c == '0) begin
`ifdef UART_WORD_IO_CHECKSUM_EN
                        ld_state_d  = L_CHK;
`else
                        load_done_d = 1'b1;
                        ld_state_d  = L_RUN;
`endif
                    end else begin
                        ld_len_d   = IDX_W'(rx_word_c);
                        ld_idx_d   = '0;
                        ld_state_d = L_DATA;
                    end
                end
            end
            L_DATA: begin
                if (word_c) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ld_idx[ADDR_WIDTH-1:0];
                    imem_wdata_d = rx_word_c;
                    ld_idx_d     = idx_inc_c;
`ifdef UART_WORD_IO_CHECKSUM_EN
                    ld_sum_d     = ld_sum + rx_word_c;
                    if (idx_inc_c == ld_len) ld_state_d = L_CHK;
`else
                    if (idx_inc_c == ld_len) begin
                        load_done_d = 1'b1;
                        ld_state_d  = L_RUN;
                    end
`endif
                end
            end
            L_CHK: begin
`ifdef UART_WORD_IO_CHECKSUM_EN
                if (word_c) begin
                    if (rx_word_c == ld_sum) load_done_d = 1'b1;
                    else                     load_err_d  = 1'b1;
                    ld_state_d = L_RUN;
                end
`else
                ld_state_d = L_RUN;
`endif
            end
            default: ld_state_d = L_RUN;
        endcase
        load_busy_d = (ld_state_d != L_RUN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ld_state   <= L_RUN;
            ld_len     <= '0;
            ld_idx     <= '0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
`ifdef UART_WORD_IO_CHECKSUM_EN
            ld_sum     <= '0;
`endif
        end else begin
            ld_state   <= ld_state_d;
            ld_len     <= ld_len_d;
            ld_idx     <= ld_idx_d;
            load_busy  <= load_busy_d;
            load_done  <= load_done_d;
            load_err   <= load_err_d;
            imem_we    <= imem_we_d;
            imem_addr  <= imem_addr_d;
            imem_wdata <= imem_wdata_d;
`ifdef UART_WORD_IO_CHECKSUM_EN
            ld_sum     <= ld_sum_d;
`endif
        end
    end

    // ---------------- RX word FIFO ----------------
    logic [W-1:0]           fifo_mem [DEPTH];
    logic [FIFO_LOG2-1:0]   wr_ptr, rd_ptr, rd_ptr_d;
    logic [FC_W-1:0]        fifo_cnt, fifo_cnt_d, cnt_after_pop_c;
    logic                   push_req_c, push_c, pop_c, full_c, drop_c;
    logic [W-1:0]           in_data_d;

    assign push_req_c = word_c && (ld_state == L_RUN);
    assign pop_c      = in_valid && in_ready;
    assign full_c     = (fifo_cnt == FIFO_FULL);
    assign push_c     = push_req_c && (!full_c || pop_c);
    assign drop_c     = push_req_c && full_c && !pop_c;

    // in_data is the registered head after this cycle's pop/push (first-word fall-through)
    always_comb begin
        rd_ptr_d        = pop_c ? rd_ptr + FIFO_LOG2'(1) : rd_ptr;
        cnt_after_pop_c = fifo_cnt - FC_W'(pop_c);
        fifo_cnt_d      = cnt_after_pop_c + FC_W'(push_c);
        in_data_d       = '0;
        if (fifo_cnt_d != '0) begin
            if (cnt_after_pop_c == '0) in_data_d = rx_word_c;
            else                       in_data_d = fifo_mem[rd_ptr_d];
        end
    end

    always_ff @(posedge CLK) begin
        if (push_c) fifo_mem[wr_ptr] <= rx_word_c;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            in_valid    <= 1'b0;
            in_data     <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + FIFO_LOG2'(1);
            rd_ptr   <= rd_ptr_d;
            fifo_cnt <= fifo_cnt_d;
            in_valid <= (fifo_cnt_d != '0);
            in_data  <= in_data_d;
            if (drop_c) rx_overflow <= 1'b1;
        end
    end

    // ---------------- TX serialiser ----------------
    tx_state_t        tx_state, tx_state_d;
    logic [W-1:0]     tx_word, tx_word_d;
    logic [CNT_W-1:0] tx_idx, tx_idx_d;
    logic             out_ready_d, tx_enable_d;
    logic [7:0]       tx_data_d;

    always_comb begin
        tx_state_d = tx_state;
        tx_word_d  = tx_word;
        tx_idx_d   = tx_idx;
        tx_data_d  = tx_data;
        case (tx_state)
            T_IDLE: begin
                if (out_ready && out_valid) begin
                    tx_word_d  = out_data;
                    tx_idx_d   = '0;
                    tx_state_d = T_WAIT_RDY;
                end
            end
            T_WAIT_RDY:  if (tx_ready)  tx_state_d = T_STROBE;
            T_STROBE:                   tx_state_d = T_WAIT_BUSY;
            T_WAIT_BUSY: if (!tx_ready) tx_state_d = T_WAIT_DONE;
            T_WAIT_DONE: begin
                if (tx_ready) begin
                    if (tx_idx == LAST_BYTE) begin
                        tx_state_d = T_IDLE;
                    end else begin
                        tx_idx_d   = tx_idx + CNT_W'(1);
                        tx_state_d = T_STROBE;
                    end
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
        out_ready_d = (tx_state_d == T_IDLE);
        tx_enable_d = (tx_state_d == T_STROBE);
        if (tx_state_d == T_STROBE) tx_data_d = get_byte(tx_word_d, byte_pos(tx_idx_d, IO_MSB));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_state  <= T_IDLE;
            tx_word   <= '0;
            tx_idx    <= '0;
            out_ready <= 1'b0;
            tx_enable <= 1'b0;
            tx_data   <= '0;
        end else begin
            tx_state  <= tx_state_d;
            tx_word   <= tx_word_d;
            tx_idx    <= tx_idx_d;
            out_ready <= out_ready_d;
            tx_enable <= tx_enable_d;
            tx_data   <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_uart_word_io.sv
// Self-checking bench for uart_word_io: directed sequence with random words, queue-based reference model.
module tb_uart_word_io;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_ready = 1'b1;
    logic        load_start = 1'b0;
    logic        load_busy, load_done, load_err, imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        in_valid;
    logic        in_ready = 1'b0;
    logic [31:0] in_data;
    logic        out_valid = 1'b0;
    logic        out_ready;
    logic [31:0] out_data = '0;
    logic        rx_overflow;

    int n_assert = 0;
    int n_fail   = 0;

    uart_word_io dut (
        .CLK(CLK), .RST_N(RST_N), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_enable(tx_enable), .tx_ready(tx_ready),
        .load_start(load_start), .load_busy(load_busy), .load_done(load_done),
        .load_err(load_err), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .rx_overflow(rx_overflow)
    );

    always #5 CLK = ~CLK;

    // Observers and sender model: record writes, done pulses, sent bytes; hold tx_ready low 10 cycles per byte
    logic [39:0] wr_q[$];
    logic [7:0]  tx_q[$];
    int          done_cnt = 0;
    int          en_run_err = 0;
    int          busy_cnt = 0;
    bit          prev_en = 1'b0;

    always @(negedge CLK) begin
        if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wdata});
        if (load_done === 1'b1) done_cnt++;
        if (tx_enable === 1'b1) begin
            tx_q.push_back(tx_data);
            if (prev_en) en_run_err++;
            busy_cnt = 10;
            tx_ready = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_ready = 1'b1;
        end
        prev_en = (tx_enable === 1'b1);
    end

    // Reference FIFO model (depth 4)
    logic [31:0] mdl_q[$];
    bit          mdl_ovf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i, input bit msb);
        int sh;
        sh = msb ? 8 * (3 - i) : 8 * i;
        return 8'((w >> sh) & 32'hFF);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit pop_too);
        @(negedge CLK);
        rx_data  = b;
        rx_valid = 1'b1;
        in_ready = pop_too;
        @(negedge CLK);
        rx_valid = 1'b0;
        in_ready = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge CLK);
    endtask

    task automatic send_word(input logic [31:0] w, input bit msb, input bit pop_last);
        for (int i = 0; i < 4; i++) send_byte(byte_of(w, i, msb), pop_last && (i == 3));
    endtask

    // Run-mode word into DUT and into model
    task automatic rx_word(input logic [31:0] w, input bit pop_last);
        send_word(w, 1'b1, pop_last);
        if (pop_last && mdl_q.size() > 0) void'(mdl_q.pop_front());
        if (mdl_q.size() < 4) mdl_q.push_back(w);
        else mdl_ovf = 1'b1;
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] exp;
        exp = mdl_q.pop_front();
        chk({tag, "_valid"}, 64'(in_valid), 64'd1);
        chk({tag, "_data"}, 64'(in_data), 64'(exp));
        in_ready = 1'b1;
        @(negedge CLK);
        in_ready = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        load_start = 1'b1;
        @(negedge CLK);
        load_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("rst_ctl", 64'({tx_data, tx_enable, load_busy, load_done, load_err, imem_we,
                            imem_addr, in_valid, out_ready, rx_overflow}), 64'd0);
        chk("rst_data", {imem_wdata, in_data}, 64'd0);
        mdl_q.delete();
        mdl_ovf = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("out_ready_after_rst", 64'(out_ready), 64'd1);
    endtask

    // Load an image; writes expected at addresses 0..N-1, load_done once unless checksum is bad
    task automatic do_load(input string tag, input logic [31:0] words[$], input bit good_sum);
        int          wb, db;
        logic [31:0] sum;
        wb  = wr_q.size();
        db  = done_cnt;
        sum = '0;
        pulse_start();
        chk({tag, "_busy"}, 64'(load_busy), 64'd1);
        send_word(32'(words.size()), 1'b0, 1'b0);
        foreach (words[i]) begin
            send_word(words[i], 1'b0, 1'b0);
            sum = sum + words[i];
        end
`ifdef UART_WORD_IO_CHECKSUM_EN
        send_word(good_sum ? sum : ~sum, 1'b0, 1'b0);
`endif
        tick(3);
        chk({tag, "_nwr"}, 64'(wr_q.size() - wb), 64'(words.size()));
        foreach (words[i]) begin
            if (wb + i < wr_q.size())
                chk($sformatf("%s_wr%0d", tag, i), 64'(wr_q[wb + i]), {24'd0, 8'(i), words[i]});
        end
`ifdef UART_WORD_IO_CHECKSUM_EN
        chk({tag, "_done"}, 64'(done_cnt - db), good_sum ? 64'd1 : 64'd0);
        chk({tag, "_err"}, 64'(load_err), good_sum ? 64'd0 : 64'd1);
`else
        chk({tag, "_done"}, 64'(done_cnt - db), 64'd1);
        chk({tag, "_err"}, 64'(load_err), 64'd0);
`endif
        chk({tag, "_idle"}, 64'(load_busy), 64'd0);
        chk({tag, "_nopush"}, 64'(in_valid), 64'd0);
    endtask

    task automatic tx_word(input string tag, input logic [31:0] w);
        int  tb0;
        int  c;
        tb0 = tx_q.size();
        @(negedge CLK);
        out_data  = w;
        out_valid = 1'b1;
        @(negedge CLK);
        out_valid = 1'b0;
        chk({tag, "_busy"}, 64'(out_ready), 64'd0);
        c = 0;
        while (out_ready !== 1'b1 && c < 600) begin
            @(negedge CLK);
            c++;
        end
        chk({tag, "_timeout"}, 64'(c < 600), 64'd1);
        chk({tag, "_nbytes"}, 64'(tx_q.size() - tb0), 64'd4);
        chk({tag, "_ready_at_done"}, 64'(tx_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (tb0 + i < tx_q.size())
                chk($sformatf("%s_b%0d", tag, i), 64'(tx_q[tb0 + i]), 64'(byte_of(w, i, 1'b1)));
        end
        chk({tag, "_en_1cyc"}, 64'(en_run_err), 64'd0);
    endtask

    initial begin
        logic [31:0] img[$];
        logic [31:0] w;
        int          wb, db;

        do_reset();

        // Loader with the reference image
        img = '{32'h12345678, 32'hDEADBEEF};
        do_load("load_def", img, 1'b1);

        // Loader with a random image
        img.delete();
        repeat ($urandom_range(1, 6)) img.push_back($urandom);
        do_load("load_rnd", img, 1'b1);

        // Run-mode RX and overflow on the fifth word
        rx_word(32'h12345678, 1'b0);
        tick(1);
        chk("rx_first_valid", 64'(in_valid), 64'd1);
        chk("rx_first_data", 64'(in_data), 64'h12345678);
        for (int i = 0; i < 4; i++) rx_word($urandom, 1'b0);
        tick(1);
        chk("rx_overflow_set", 64'(rx_overflow), 64'(mdl_ovf));
        for (int i = 0; i < 4; i++) pop_chk($sformatf("rx_ovf_pop%0d", i));
        chk("rx_ovf_empty", 64'(in_valid), 64'd0);

        // Full FIFO with simultaneous pop and push
        do_reset();
        for (int i = 0; i < 4; i++) rx_word($urandom, 1'b0);
        rx_word($urandom, 1'b1);
        tick(1);
        chk("full_pp_no_ovf", 64'(rx_overflow), 64'd0);
        for (int i = 0; i < 4; i++) pop_chk($sformatf("full_pp_pop%0d", i));
        tick(1);
        chk("full_pp_empty", 64'(in_valid), 64'd0);

        // TX serialiser
        tx_word("tx_ref", 32'hA1B2C3D4);
        tx_word("tx_rnd", $urandom);

        // Oversized header
        wb = wr_q.size();
        db = done_cnt;
        pulse_start();
        send_word(32'h00000101, 1'b0, 1'b0);
        tick(2);
        chk("hdr_big_err", 64'(load_err), 64'd1);
        chk("hdr_big_busy", 64'(load_busy), 64'd0);
        chk("hdr_big_nowr", 64'(wr_q.size() - wb), 64'd0);
        chk("hdr_big_nodone", 64'(done_cnt - db), 64'd0);
        rx_word(32'hCAFEF00D, 1'b0);
        tick(1);
        pop_chk("hdr_big_runmode");

        // Zero-length image
        img.delete();
        do_load("hdr_zero", img, 1'b1);

        // Reset in the middle of a load discards it
        pulse_start();
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        do_reset();
        chk("midrst_busy", 64'(load_busy), 64'd0);
        rx_word(32'h01020304, 1'b0);
        tick(1);
        pop_chk("midrst_fifo");

`ifdef UART_WORD_IO_CHECKSUM_EN
        // Bad checksum keeps the writes but flags an error
        img = '{$urandom, $urandom};
        do_load("bad_sum", img, 1'b0);
`endif

        w = $urandom;
        tx_word("tx_last", w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
